ysyx_23060077_mdu: RTL
======================

// Module: ysyx_23060077_mdu
// PURPOSE
//  Parametrised iterative multiply/divide unit for the RV32M/RV64M extension.
//  Sits beside the single-cycle ALU in the execute stage and takes over all MUL*/DIV*/REM* ops.
//  Operands are captured on accept; the result is held until consumed (valid/ready both sides).
//  Adds over the previous EXU mul/div path: XLEN/throughput generics, RISC-V corner cases, flush.
// PARAMETERS
//  XLEN           32  operand/result width (32 or 64)
//  MUL_BITS_CYC   2   multiplier bits retired per cycle; must divide XLEN (1,2,4)
// PORTS
//  clock      in   1     system clock, rising edge
//  reset      in   1     asynchronous, active-high reset
//  in_valid   in   1     request valid (from ID/EX handshake)
//  in_ready   out  1     unit idle and able to accept
//  funct3     in   3     RV M-ext funct3: 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  src1       in   XLEN  rs1 operand (multiplicand/dividend)
//  src2       in   XLEN  rs2 operand (multiplier/divisor)
//  flush      in   1     kill in-flight op (branch redirect/trap)
//  out_valid  out  1     result valid
//  out_ready  in   1     EX->WB accepts result
//  result     out  XLEN  selected product half / quotient / remainder
//  busy       out  1     op accepted and not yet consumed (stall source for ID)
// BEHAVIOUR
//  Reset (async): state=IDLE, in_ready=1 once reset deasserts, out_valid=0, result=0, busy=0.
//  FSM: IDLE -> MUL | DIV | DONE ; MUL -> DONE ; DIV -> DONE ; DONE -> IDLE.
//  in_ready = (state==IDLE) & !flush. Accept = in_valid & in_ready; funct3/src1/src2 registered then.
//  MUL: 2*XLEN shift-add on |operand| magnitudes; XLEN/MUL_BITS_CYC cycles in MUL;
//   sign fix-up on the final cycle: MUL/MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned.
//   MUL returns product[XLEN-1:0]; MULH* return product[2*XLEN-1:XLEN].
//  DIV: restoring radix-2, one quotient bit/cycle, XLEN cycles in DIV; signed ops divide magnitudes,
//   quotient negated iff operand signs differ, remainder takes dividend sign.
//  Corner cases resolved at accept, bypass DIV state (IDLE -> DONE directly):
//   divisor==0  : quotient = all ones, remainder = src1.
//   signed overflow (src1 = -2^(XLEN-1), src2 = -1, DIV/REM): quotient = src1, remainder = 0.
//  Latency (accept edge -> out_valid high): MUL = XLEN/MUL_BITS_CYC + 1 cycles, DIV = XLEN + 1,
//   corner case = 1. No dependence on inputs after accept.
//  DONE: out_valid=1, result stable until out_valid & out_ready; that edge returns to IDLE.
//   in_ready stays 0 in DONE (no accept in the same cycle as consume; one bubble by design).
//  busy = (state != IDLE).
//  flush: any state -> IDLE on the next edge; counter cleared, out_valid drops, result not delivered.
//   flush with in_valid in IDLE: not accepted. flush with out_ready in DONE: flush wins, no double-count.
//  reset asserted mid-op: immediate return to reset values, no partial result visible.
//  Iteration counter width clog2(XLEN)+1; it never wraps: leaving MUL/DIV is exactly at terminal count.
// STRUCTURE
//  Shared define file: funct3 op codes (MDU_MUL..MDU_REMU), FSM state encoding (IDLE/MUL/DIV/DONE).
//  Sub-module ysyx_23060077_mdu_div: restoring divider core (start, dividend, divisor, step enable,
//   quotient, remainder) so a radix-4 core can be swapped in later; multiplier datapath stays inline.
//  Sign fix-up and result mux shared between mul and div paths in the top.
// TESTING
//  XLEN=32: MUL 7 x -3 -> result 0xFFFFFFEB, out_valid 17 cycles after accept (MUL_BITS_CYC=2).
//  MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU -1 x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU same -> 0xFFFFFFFE.
//  DIV -7 / 2 -> -3 (0xFFFFFFFD), REM -7 / 2 -> -1, DIVU 100/7 -> 14, REMU -> 2, 33 cycles each.
//  DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, REM -> 0; all 1-cycle latency.
//  Backpressure: out_ready held 0 for 10 cycles in DONE -> result and out_valid stable, in_ready=0 throughout.
//  Flush at cycle 5 of a DIV and async reset mid-MUL -> IDLE next edge / immediately, out_valid never pulses,
//   following MULHU 0xFFFFFFFF x 2 -> 0x00000001 correct.

Source files
------------

// File: rtl/ysyx_23060077_mdu_pkg.sv
// Shared definitions for the ysyx_23060077 multiply/divide unit.
//  - mdu_op_e    : RV32M/RV64M funct3 operation codes
//  - mdu_state_e : sequencer state encoding
//  - op_rs1_signed / op_rs2_signed : operand signedness per op
package ysyx_23060077_mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_e;

  // rs1 is treated as two's complement for these ops
  function automatic logic op_rs1_signed(input logic [2:0] op);
    case (op)
      MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM: op_rs1_signed = 1'b1;
      default:                                         op_rs1_signed = 1'b0;
    endcase
  endfunction

  // rs2 is treated as two's complement for these ops
  function automatic logic op_rs2_signed(input logic [2:0] op);
    case (op)
      MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM: op_rs2_signed = 1'b1;
      default:                             op_rs2_signed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060077_mdu_div.sv
// Restoring radix-2 divider core on unsigned magnitudes.
//  clock_i, reset_i      : clock, async active-high reset
//  start_i               : load operands AND retire the first quotient bit
//  step_en_i             : retire one more quotient bit
//  dividend_i, divisor_i : unsigned operands, sampled on start_i
//  quotient_o, remainder_o : running quotient/remainder registers
// After start plus XLEN-1 steps, quotient_o/remainder_o hold the final result.
module ysyx_23060077_mdu_div #(
  parameter int XLEN = 32
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            step_en_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dsr_q, dsr_d;
  logic [XLEN-1:0] base_rem_s;
  logic [XLEN-1:0] base_quo_s;
  logic [XLEN:0]   trial_s;

  // One restoring step; start feeds the step from the fresh operands
  always_comb begin
    base_rem_s = start_i ? '0 : rem_q;
    base_quo_s = start_i ? dividend_i : quo_q;
    dsr_d      = start_i ? divisor_i : dsr_q;
    trial_s    = {base_rem_s, base_quo_s[XLEN-1]} - {1'b0, dsr_d};
    if (!trial_s[XLEN]) begin
      rem_d = trial_s[XLEN-1:0];
      quo_d = {base_quo_s[XLEN-2:0], 1'b1};
    end else begin
      rem_d = {base_rem_s[XLEN-2:0], base_quo_s[XLEN-1]};
      quo_d = {base_quo_s[XLEN-2:0], 1'b0};
    end
  end

  // Divider state registers
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
    end else if (start_i || step_en_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dsr_q <= dsr_d;
    end else begin
      rem_q <= rem_q;
      quo_q <= quo_q;
      dsr_q <= dsr_q;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/ysyx_23060077_mdu.sv
// Iterative RV32M/RV64M multiply/divide unit.
//  clock, reset          : clock, async active-high reset
//  in_valid/in_ready     : request handshake; funct3/src1/src2 captured on accept
//  flush                 : kill any in-flight op, back to idle next edge
//  out_valid/out_ready   : result handshake; result held until consumed
//  result                : product half / quotient / remainder
//  busy                  : op accepted and not yet consumed
// Multiplier is inline shift-add on magnitudes; divider is a swappable sub-core.
module ysyx_23060077_mdu
  import ysyx_23060077_mdu_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int MUL_BITS_CYC = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / MUL_BITS_CYC - 1);
  // DIV state spends its last cycle on sign fix-up, the first bit is retired on accept
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);

  mdu_state_e        state_q, state_d;
  mdu_op_e           op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              out_valid_q, out_valid_d;

  logic              accept_s;
  logic              s1_neg_s, s2_neg_s;
  logic [XLEN-1:0]   s1_mag_s, s2_mag_s;
  logic              div_zero_s, div_ovf_s, corner_s;
  logic [XLEN-1:0]   corner_res_s;
  logic [2*XLEN-1:0] prod_next_s, prod_fix_s;
  logic [XLEN-1:0]   mul_res_s;
  logic [XLEN-1:0]   quo_s, rem_s, quo_fix_s, rem_fix_s, div_res_s;
  logic              div_start_s, div_step_s;

  assign in_ready  = (state_q == ST_IDLE) && !flush;
  assign accept_s  = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = (state_q != ST_IDLE);

  // Operand magnitudes and divide corner cases, evaluated on the request inputs
  always_comb begin
    s1_neg_s   = op_rs1_signed(funct3) && src1[XLEN-1];
    s2_neg_s   = op_rs2_signed(funct3) && src2[XLEN-1];
    s1_mag_s   = s1_neg_s ? -src1 : src1;
    s2_mag_s   = s2_neg_s ? -src2 : src2;
    div_zero_s = (src2 == '0);
    div_ovf_s  = ((funct3 == MDU_DIV) || (funct3 == MDU_REM)) &&
                 (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
    corner_s   = div_zero_s || div_ovf_s;
    // funct3[1] selects remainder for the divide group
    if (div_zero_s) begin
      corner_res_s = funct3[1] ? src1 : '1;
    end else begin
      corner_res_s = funct3[1] ? '0 : src1;
    end
  end

  // Shift-add step retiring MUL_BITS_CYC multiplier bits, plus sign fix-up
  always_comb begin
    prod_next_s = prod_q;
    for (int i = 0; i < MUL_BITS_CYC; i++) begin
      if (mplier_q[i]) begin
        prod_next_s = prod_next_s + (mcand_q << i);
      end else begin
        prod_next_s = prod_next_s;
      end
    end
    prod_fix_s = neg_q ? -prod_next_s : prod_next_s;
    mul_res_s  = (op_q == MDU_MUL) ? prod_fix_s[XLEN-1:0] : prod_fix_s[2*XLEN-1:XLEN];
  end

  // Divide sign fix-up: quotient by sign difference, remainder follows dividend
  always_comb begin
    quo_fix_s = neg_q ? -quo_s : quo_s;
    rem_fix_s = rneg_q ? -rem_s : rem_s;
    div_res_s = op_q[1] ? rem_fix_s : quo_fix_s;
  end

  ysyx_23060077_mdu_div #(.XLEN(XLEN)) u_div (
    .clock_i     (clock),
    .reset_i     (reset),
    .start_i     (div_start_s),
    .step_en_i   (div_step_s),
    .dividend_i  (s1_mag_s),
    .divisor_i   (s2_mag_s),
    .quotient_o  (quo_s),
    .remainder_o (rem_s)
  );

  // Sequencer next state and datapath loads; flush overrides everything
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    neg_d       = neg_q;
    rneg_d      = rneg_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    div_start_s = 1'b0;
    div_step_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          op_d   = mdu_op_e'(funct3);
          neg_d  = s1_neg_s ^ s2_neg_s;
          rneg_d = s1_neg_s;
          cnt_d  = '0;
          if (!funct3[2]) begin
            state_d  = ST_MUL;
            mcand_d  = {{XLEN{1'b0}}, s1_mag_s};
            mplier_d = s2_mag_s;
            prod_d   = '0;
          end else if (corner_s) begin
            state_d     = ST_DONE;
            result_d    = corner_res_s;
            out_valid_d = 1'b1;
          end else begin
            state_d     = ST_DIV;
            div_start_s = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        prod_d   = prod_next_s;
        mcand_d  = mcand_q << MUL_BITS_CYC;
        mplier_d = mplier_q >> MUL_BITS_CYC;
        if (cnt_q == MUL_LAST) begin
          state_d     = ST_DONE;
          result_d    = mul_res_s;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DIV: begin
        if (cnt_q == DIV_LAST) begin
          state_d     = ST_DONE;
          result_d    = div_res_s;
          out_valid_d = 1'b1;
        end else begin
          div_step_s = 1'b1;
          cnt_d      = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        cnt_d       = '0;
      end
    endcase
    state_d     = flush ? ST_IDLE : state_d;
    cnt_d       = flush ? '0 : cnt_d;
    out_valid_d = flush ? 1'b0 : out_valid_d;
    div_start_s = div_start_s && !flush;
    div_step_s  = div_step_s && !flush;
  end

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= MDU_MUL;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      neg_q       <= neg_d;
      rneg_q      <= rneg_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
